// File: rtl/uart_stream_pkg.sv
// Shared constants for the UART stream master: register map, RX-empty marker, FSM encoding.
package uart_stream_pkg;

   // Register offsets from the UART base address
   localparam logic [31:0] REG_DIV    = 32'd0;
   localparam logic [31:0] REG_DAT    = 32'd4;
   localparam logic [31:0] REG_CTS    = 32'd8;
   localparam logic [31:0] REG_STATUS = 32'd12;

   // Data register read value meaning "no byte received"
   localparam logic [31:0] RX_EMPTY = 32'hffff_ffff;

   // Write strobes
   localparam logic [3:0] WSTRB_READ = 4'b0000;
   localparam logic [3:0] WSTRB_BYTE = 4'b0001;
   localparam logic [3:0] WSTRB_WORD = 4'b1111;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_INIT     = 3'd0;
   localparam state_t ST_GAP      = 3'd1;
   localparam state_t ST_IDLE     = 3'd2;
   localparam state_t ST_TX_POLL  = 3'd3;
   localparam state_t ST_TX_WRITE = 3'd4;
   localparam state_t ST_RX_READ  = 3'd5;

   // Round-robin bit values: last side served
   localparam logic RR_TX = 1'b0;
   localparam logic RR_RX = 1'b1;

   // Absolute address of a UART register
   function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [31:0] off);
      return base + off;
   endfunction

endpackage

// File: rtl/uart_byte_slot.sv
// One-entry 8-bit valid/ready holding register.
module uart_byte_slot (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic [7:0] in_data_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   output logic [7:0] out_data_o,
   output logic       out_valid_o,
   input  logic       out_ready_i
);

   logic       full_q, full_d;
   logic [7:0] data_q, data_d;

   assign in_ready_o  = en_i && !full_q;
   assign out_valid_o = full_q;
   assign out_data_o  = data_q;

   // Fill on input handshake, empty on output handshake; both cannot coincide
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (in_valid_i && in_ready_o) begin
         full_d = 1'b1;
         data_d = in_data_i;
      end else if (full_q && out_ready_i) begin
         full_d = 1'b0;
      end
   end

   // Slot state registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         data_q <= 8'h00;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/uart_stream_master.sv
// Bus initiator turning TX/RX byte streams into UART register accesses.
module uart_stream_master
   import uart_stream_pkg::*;
#(
   parameter logic [31:0] UART_ADDR = 32'hffff_ffff,
   parameter logic [31:0] DIVISOR   = 32'd104
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        mem_valid,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        init_done
);

   state_t      state_q, state_d;
   state_t      gap_next_q, gap_next_d;
   logic        rr_q, rr_d;
   logic        mem_valid_q, mem_valid_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic        init_done_q, init_done_d;

   logic        tx_pend;
   logic        tx_clear;
   logic [7:0]  tx_byte;
   logic        rx_pend;
   logic        rx_fill;

   // TX slot accepts bytes only once the divisor is programmed
   uart_byte_slot u_tx_slot (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .en_i        (init_done_q),
      .in_data_i   (tx_data),
      .in_valid_i  (tx_valid),
      .in_ready_o  (tx_ready),
      .out_data_o  (tx_byte),
      .out_valid_o (tx_pend),
      .out_ready_i (tx_clear)
   );

   // RX slot: its input-ready is exactly "slot empty", which is what makes RX pending
   uart_byte_slot u_rx_slot (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .en_i        (1'b1),
      .in_data_i   (mem_rdata[7:0]),
      .in_valid_i  (rx_fill),
      .in_ready_o  (rx_pend),
      .out_data_o  (rx_data),
      .out_valid_o (rx_valid),
      .out_ready_i (rx_ready)
   );

   assign mem_valid = mem_valid_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_wstrb = mem_wstrb_q;
   assign init_done = init_done_q;

   // Sequencer: each transaction is launched on the edge that enters its state
   always_comb begin
      state_d     = state_q;
      gap_next_d  = gap_next_q;
      rr_d        = rr_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_wstrb_d = mem_wstrb_q;
      init_done_d = init_done_q;
      tx_clear    = 1'b0;
      rx_fill     = 1'b0;

      case (state_q)
         ST_INIT: begin
            // mem_valid is only low here in the first cycle after reset
            if (!mem_valid_q) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = reg_addr(UART_ADDR, REG_DIV);
               mem_wdata_d = DIVISOR;
               mem_wstrb_d = WSTRB_WORD;
            end else if (mem_ready) begin
               mem_valid_d = 1'b0;
               init_done_d = 1'b1;
               state_d     = ST_GAP;
               gap_next_d  = ST_IDLE;
            end
         end

         ST_GAP: begin
            state_d = gap_next_q;
            if (gap_next_q == ST_TX_POLL) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = reg_addr(UART_ADDR, REG_STATUS);
               mem_wdata_d = 32'h0;
               mem_wstrb_d = WSTRB_READ;
            end else if (gap_next_q == ST_TX_WRITE) begin
               mem_valid_d = 1'b1;
               mem_addr_d  = reg_addr(UART_ADDR, REG_DAT);
               mem_wdata_d = {24'h0, tx_byte};
               mem_wstrb_d = WSTRB_BYTE;
            end
         end

         ST_IDLE: begin
            // Both pending: serve the side that was not served last
            if (tx_pend && (!rx_pend || rr_q == RR_RX)) begin
               rr_d        = RR_TX;
               state_d     = ST_TX_POLL;
               mem_valid_d = 1'b1;
               mem_addr_d  = reg_addr(UART_ADDR, REG_STATUS);
               mem_wdata_d = 32'h0;
               mem_wstrb_d = WSTRB_READ;
            end else if (rx_pend) begin
               rr_d        = RR_RX;
               state_d     = ST_RX_READ;
               mem_valid_d = 1'b1;
               mem_addr_d  = reg_addr(UART_ADDR, REG_DAT);
               mem_wdata_d = 32'h0;
               mem_wstrb_d = WSTRB_READ;
            end
         end

         ST_TX_POLL: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               state_d     = ST_GAP;
               // Busy keeps polling without giving RX a turn
               gap_next_d  = mem_rdata[0] ? ST_TX_POLL : ST_TX_WRITE;
            end
         end

         ST_TX_WRITE: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               tx_clear    = 1'b1;
               state_d     = ST_GAP;
               gap_next_d  = ST_IDLE;
            end
         end

         ST_RX_READ: begin
            if (mem_ready) begin
               mem_valid_d = 1'b0;
               rx_fill     = (mem_rdata != RX_EMPTY);
               state_d     = ST_GAP;
               gap_next_d  = ST_IDLE;
            end
         end

         default: begin
            mem_valid_d = 1'b0;
            state_d     = ST_INIT;
         end
      endcase
   end

   // Sequencer and bus request registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_INIT;
         gap_next_q  <= ST_IDLE;
         rr_q        <= RR_TX;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         mem_wstrb_q <= 4'h0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         gap_next_q  <= gap_next_d;
         rr_q        <= rr_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wstrb_q <= mem_wstrb_d;
         init_done_q <= init_done_d;
      end
   end

endmodule

// File: tb/tb_uart_stream_master.sv
// Self-checking bench for uart_stream_master: peripheral responder, stream model, directed phases.
module tb_uart_stream_master;

   localparam logic [31:0] BASE = 32'h1000_0010;

   logic        clk;
   logic        resetn;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        init_done;

   uart_stream_master #(
      .UART_ADDR (BASE),
      .DIVISOR   (32'd104)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- peripheral responder ----------------
   int          lat = 2;   // cycles mem_valid is seen high before ready is raised
   int          wait_cnt = 0;
   logic        status_q[$];
   logic [31:0] rxd_q[$];
   logic [31:0] resp_off;

   initial begin
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!resetn || mem_ready) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
         end else if (mem_valid) begin
            wait_cnt++;
            if (wait_cnt > lat) begin
               mem_ready = 1'b1;
               resp_off  = mem_addr - BASE;
               if (mem_wstrb != 4'h0) mem_rdata = 32'h0;
               else if (resp_off == 32'd12)
                  mem_rdata = 32'h8000_00f0 | {31'h0, (status_q.size() > 0) ? status_q.pop_front() : 1'b0};
               else
                  mem_rdata = (rxd_q.size() > 0) ? rxd_q.pop_front() : 32'hffff_ffff;
            end
         end
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [31:0] off;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [3:0]  wstrb;
      int          st;
      int          en;
   } txn_t;

   txn_t        log_q[$];
   int          cyc = 0;
   int          cur_start = 0;
   int          n_acc = 0;
   int          tx_acc_cyc = 0;
   logic        m_init = 1'b0;
   logic        m_txf = 1'b0;
   logic        m_rxf = 1'b0;
   logic [7:0]  m_txb = 8'h0;
   logic [7:0]  m_rxb = 8'h0;
   logic        poll_free = 1'b0;
   logic        pre_tx_rdy, pre_rxf, legal;
   txn_t        t;

   initial begin
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) begin
            m_init    = 1'b0;
            m_txf     = 1'b0;
            m_rxf     = 1'b0;
            poll_free = 1'b0;
         end else begin
            cyc++;
            pre_tx_rdy = m_init && !m_txf;
            pre_rxf    = m_rxf;
            if (mem_valid && mem_ready) begin
               t.off   = mem_addr - BASE;
               t.wdata = mem_wdata;
               t.rdata = mem_rdata;
               t.wstrb = mem_wstrb;
               t.st    = cur_start;
               t.en    = cyc;
               log_q.push_back(t);
               legal = (!m_init && t.off == 32'd0 && t.wstrb == 4'hf) ||
                       (m_init && ((t.off == 32'd4 && (t.wstrb == 4'h1 || t.wstrb == 4'h0)) ||
                                   (t.off == 32'd12 && t.wstrb == 4'h0)));
               check("txn_legal", legal, 1'b1);
               if (!m_init) begin
                  check("div_wdata", t.wdata, 32'd104);
                  m_init = 1'b1;
               end else if (t.off == 32'd4 && t.wstrb == 4'h1) begin
                  check("tx_write_pending", m_txf, 1'b1);
                  check("tx_write_after_free_poll", poll_free, 1'b1);
                  check("tx_write_data", t.wdata, {24'h0, m_txb});
                  m_txf     = 1'b0;
                  poll_free = 1'b0;
               end else if (t.off == 32'd4) begin
                  check("rx_read_slot_empty", m_rxf, 1'b0);
                  poll_free = 1'b0;
                  if (t.rdata != 32'hffff_ffff) begin
                     m_rxf = 1'b1;
                     m_rxb = t.rdata[7:0];
                  end
               end else if (t.off == 32'd12) begin
                  check("poll_tx_pending", m_txf, 1'b1);
                  poll_free = !t.rdata[0];
               end
            end
            if (tx_valid && pre_tx_rdy) begin
               m_txf      = 1'b1;
               m_txb      = tx_data;
               tx_acc_cyc = cyc;
               n_acc++;
            end
            if (pre_rxf && rx_ready) m_rxf = 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   logic        p_valid = 1'b0, p_ready = 1'b0, p_resetn = 1'b0;
   logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
   logic [3:0]  p_wstrb = 4'h0;

   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            check("rst_mem_valid", mem_valid, 1'b0);
            check("rst_mem_addr", mem_addr, 32'h0);
            check("rst_mem_wdata", mem_wdata, 32'h0);
            check("rst_mem_wstrb", mem_wstrb, 4'h0);
            check("rst_tx_ready", tx_ready, 1'b0);
            check("rst_rx_valid", rx_valid, 1'b0);
            check("rst_rx_data", rx_data, 8'h0);
            check("rst_init_done", init_done, 1'b0);
         end else begin
            check("init_done", init_done, m_init);
            check("tx_ready", tx_ready, m_init && !m_txf);
            check("rx_valid", rx_valid, m_rxf);
            if (m_rxf) check("rx_data", rx_data, m_rxb);
            if (p_resetn && p_valid && !p_ready) begin
               check("bus_hold_valid", mem_valid, 1'b1);
               check("bus_hold_addr", mem_addr, p_addr);
               check("bus_hold_wdata", mem_wdata, p_wdata);
               check("bus_hold_wstrb", mem_wstrb, p_wstrb);
            end
            if (p_resetn && p_valid && p_ready) check("bus_drop_after_ready", mem_valid, 1'b0);
            if (mem_valid && !p_valid) cur_start = cyc;
         end
         p_valid  = mem_valid;
         p_ready  = mem_ready;
         p_addr   = mem_addr;
         p_wdata  = mem_wdata;
         p_wstrb  = mem_wstrb;
         p_resetn = resetn;
      end
   end

   // ---------------- directed phases ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int k = 0;
      while (log_q.size() < n && k < budget) begin
         step();
         k++;
      end
      check(name, log_q.size() >= n, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int budget);
      int start = n_acc;
      int k = 0;
      tx_data  = b;
      tx_valid = 1'b1;
      while (n_acc == start && k < budget) begin
         step();
         k++;
      end
      check("tx_accept_in_time", n_acc != start, 1'b1);
   endtask

   function automatic logic [7:0] kind(input txn_t x);
      if (x.off == 32'd12) return "T";
      if (x.off == 32'd4 && x.wstrb == 4'h1) return "W";
      if (x.off == 32'd4) return "R";
      return "I";
   endfunction

   logic [7:0] e_bytes[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
   logic [7:0] pat[3]     = '{"R", "T", "W"};
   int         n0;
   int         k;
   int         nacc_n;

   initial begin
      resetn   = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h0;
      rx_ready = 1'b0;
      rxd_q    = '{32'hffff_ffff, 32'h0000_0041};

      // Reset release and divisor write
      repeat (3) step();
      resetn = 1'b1;
      step();
      check("init_req_valid", mem_valid, 1'b1);
      check("init_req_addr", mem_addr, BASE);
      check("init_req_wdata", mem_wdata, 32'd104);
      check("init_req_wstrb", mem_wstrb, 4'hf);
      wait_log(1, 20, "init_done_in_time");
      check("init_first_off", log_q[0].off, 32'd0);
      check("init_ready_after_2", log_q[0].en - log_q[0].st, 3);
      check("init_done_after_ready", init_done, 1'b1);

      // RX: empty read, then a byte; slot full blocks further reads
      k = 0;
      while (!rx_valid && k < 100) begin
         step();
         k++;
      end
      check("rx_byte_arrived", rx_valid, 1'b1);
      check("rx_byte_value", rx_data, 8'h41);
      check("rx_empty_read_first", log_q[1].rdata, 32'hffff_ffff);
      check("rx_read_count", log_q.size(), 3);
      n0 = log_q.size();
      repeat (20) step();
      check("no_read_while_full", log_q.size(), n0);
      check("rx_valid_held", rx_valid, 1'b1);

      // TX latency from IDLE with 1-cycle ready and not busy
      lat = 1;
      n0  = log_q.size();
      send_byte(8'h5a, 20);
      tx_valid = 1'b0;
      nacc_n   = tx_acc_cyc;
      wait_log(n0 + 2, 50, "tx_seq_done");
      check("tx_poll_off", log_q[n0].off, 32'd12);
      check("tx_poll_start", log_q[n0].st, nacc_n + 1);
      check("tx_write_off", log_q[n0 + 1].off, 32'd4);
      check("tx_write_wdata", log_q[n0 + 1].wdata, 32'h5a);
      check("tx_write_wstrb", log_q[n0 + 1].wstrb, 4'b0001);
      check("tx_write_start", log_q[n0 + 1].st, nacc_n + 4);
      check("tx_ready_back", tx_ready, 1'b1);

      // Busy three times, then free
      status_q = '{1'b1, 1'b1, 1'b1, 1'b0};
      n0       = log_q.size();
      send_byte(8'hc3, 20);
      tx_valid = 1'b0;
      wait_log(n0 + 5, 80, "busy_seq_done");
      repeat (5) step();
      check("busy_seq_len", log_q.size(), n0 + 5);
      for (int i = 0; i < 4; i++) check("busy_poll_off", log_q[n0 + i].off, 32'd12);
      check("busy_write_data", log_q[n0 + 4].wdata, 32'hc3);
      for (int i = 1; i < 5; i++) check("busy_gap_one", log_q[n0 + i].st - log_q[n0 + i - 1].en, 1);

      // Continuous TX with RX draining: sequences alternate
      rxd_q    = '{32'hffff_ffff, 32'h0000_0033, 32'hffff_ffff, 32'h0000_007e};
      rx_ready = 1'b1;
      n0       = log_q.size();
      foreach (e_bytes[i]) send_byte(e_bytes[i], 100);
      tx_valid = 1'b0;
      wait_log(n0 + 18, 300, "alt_seq_done");
      for (int i = 0; i < 18; i++) check("alternation", kind(log_q[n0 + i]), pat[i % 3]);

      // Reset during a stalled data write
      lat = 10;
      send_byte(8'h99, 100);
      tx_valid = 1'b0;
      k = 0;
      while (!(mem_valid && mem_addr == BASE + 32'd4 && mem_wstrb == 4'b0001) && k < 300) begin
         step();
         k++;
      end
      check("abort_write_seen", mem_valid && mem_addr == BASE + 32'd4 && mem_wstrb == 4'b0001, 1'b1);
      step();
      step();
      @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      check("abort_valid_low", mem_valid, 1'b0);
      check("abort_tx_ready_low", tx_ready, 1'b0);
      check("abort_init_done_low", init_done, 1'b0);
      lat = 2;
      step();
      step();
      resetn = 1'b1;
      n0 = log_q.size();
      step();
      check("reinit_valid", mem_valid, 1'b1);
      check("reinit_addr", mem_addr, BASE);
      wait_log(n0 + 1, 20, "reinit_done");
      check("reinit_off", log_q[n0].off, 32'd0);
      check("reinit_wdata", log_q[n0].wdata, 32'd104);
      repeat (3) step();
      check("reinit_tx_slot_empty", tx_ready, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_stream_master.md
# uart_stream_master

Bus initiator that drives the memory-mapped UART peripheral's register interface. It converts a byte-wide TX valid/ready stream into data-register writes and polls the data register to produce an RX valid/ready stream. It sits between stream-based logic (e.g. a hashing front end) and the UART peripheral, so hardware moves bytes over the serial link without a CPU.

## Interface
- `UART_ADDR`, 32'hffff_ffff: base address of the UART peripheral.
- `DIVISOR`, 32'd104: value written to the divisor register after reset.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `mem_valid` out 1: transaction request.
- `mem_addr` out 32: register address.
- `mem_wdata` out 32: write data.
- `mem_wstrb` out 4: byte strobes; 4'b0000 means read.
- `mem_ready` in 1: transaction complete.
- `mem_rdata` in 32: read data, valid when `mem_ready` is high.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: TX byte offered.
- `tx_ready` out 1: TX slot empty.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: RX slot full.
- `rx_ready` in 1: consumer takes the RX byte.
- `init_done` out 1: divisor write completed.

## Operation
- Register map, as offsets from `UART_ADDR`:
  - +0 divisor.
  - +4 data.
  - +8 CTS.
  - +12 status; bit0 = send busy.
- Reset values: `mem_valid`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `init_done`=0. Both slots are empty and the round-robin bit = TX.
- FSM states and transitions:
  - INIT: write `DIVISOR` to +0 with wstrb 4'hf. On ready, set `init_done`=1 and go to GAP.
  - GAP: one idle cycle, then IDLE.
  - IDLE: service the pending requesters.
    - TX pending = TX slot full. RX pending = RX slot empty.
    - If both are pending, serve the side opposite the round-robin bit.
    - If one is pending, serve it.
    - The round-robin bit records the last side served.
  - TX_POLL: read +12. On ready:
    - `mem_rdata[0]`=1 → GAP, then re-poll. TX stays pending.
    - `mem_rdata[0]`=0 → GAP, then TX_WRITE.
  - TX_WRITE: write +4 with wdata {24'h0, byte} and wstrb 4'b0001. On ready, clear the TX slot and go to GAP.
  - RX_READ: read +4 with wstrb 0. On ready:
    - `mem_rdata`==32'hffff_ffff → empty, discard.
    - Otherwise load `mem_rdata[7:0]` into the RX slot and set `rx_valid`.
    - Then go to GAP.
- TX slot: `tx_ready` = `init_done` && slot empty. It captures `tx_data` when `tx_valid`&&`tx_ready`.
- RX slot: `rx_valid` stays high and `rx_data` stays stable until `rx_valid`&&`rx_ready`. No RX_READ is issued while the slot is full, so no byte is ever dropped.
- A TX handshake and a slot clear in the same cycle cannot occur, because `tx_ready` is low while the slot is full. An RX slot clear and an RX fill in the same cycle cannot occur, for the same reason.
- Stream handshakes are accepted during any state once `init_done`=1.
- Reset asserted mid-transaction: all outputs take their reset values immediately and the transaction is abandoned. After release, INIT repeats.

## Timing
- Bus rules:
  - `mem_valid` is registered.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` stay stable while `mem_valid`=1, until `mem_ready` is sampled high.
  - `mem_valid` drops in the cycle after ready and stays low for exactly one GAP cycle.
  - There is no timeout; a data-register write may stall arbitrarily long on the peripheral's wait.
- INIT request: `mem_valid`=1 in the first clock edge after `resetn` deasserts.
- `init_done` rises in the cycle after the INIT ready.
- TX latency, with the byte accepted at edge N while in IDLE: TX_POLL `mem_valid` at N+1. With a 1-cycle ready and not busy, TX_WRITE `mem_valid` at N+4.
- `rx_valid` is asserted in the cycle after the RX_READ ready that returns a byte.

## Structure
- Package `uart_stream_pkg` holds:
  - register offset constants (DIV, DAT, CTS, STATUS);
  - the `RX_EMPTY` = 32'hffff_ffff constant;
  - the FSM state enum (INIT, GAP, IDLE, TX_POLL, TX_WRITE, RX_READ).
- Sub-module `uart_byte_slot`: a one-entry 8-bit valid/ready holding register. It is instantiated twice, once for TX and once for RX.

## Test plan
- Reset release, ready after 2 cycles → one write to `UART_ADDR` with wdata=104 and wstrb=4'hf; `init_done`=1 afterwards; no other transaction precedes it.
- `tx_data`=8'h5A, status returns 0 → read of +12, then write of +4 with wdata=32'h5A and wstrb=4'b0001; `tx_ready` returns to 1 after the write ready.
- Status returns busy=1 three times, then 0 → exactly 4 status reads with a 1-cycle gap between each, then a single data write of the pending byte.
- RX read returns 32'hffff_ffff → `rx_valid` stays 0. The next read returns 32'h41 → `rx_valid`=1 and `rx_data`=8'h41. With `rx_ready` held low for 20 cycles, no read of +4 is issued.
- TX pending and RX slot empty continuously → issued transactions alternate between TX and RX sequences; no address is ever outside +0..+12.
- Assert `resetn` low while `mem_valid`=1 on a TX_WRITE → `mem_valid` is 0 in the same cycle, the TX slot is empty, and after release the divisor write repeats.
